// File: rtl/card_shoe.sv
// card_shoe: 52-card deck store with LFSR-driven Fisher-Yates shuffle and
// single-card dealing for the blackjack datapath.
module card_shoe #(
  parameter int unsigned PEN_THRESHOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  input  logic       shuffle,
  input  logic       req,
  output logic       card_valid,
  output logic [4:0] card_value,
  output logic [3:0] card_rank,
  output logic [5:0] remaining,
  output logic       ready,
  output logic       busy,
  output logic       low_water,
  output logic       underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SHUFFLE,
    S_READY
  } state_t;

  localparam logic [6:0] PEN_T = 7'(PEN_THRESHOLD);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [5:0] i_q, i_d;
  logic [5:0] ptr_q, ptr_d;
  logic [5:0] remaining_q, remaining_d;
  logic       card_valid_q, card_valid_d;
  logic [4:0] card_value_q, card_value_d;
  logic [3:0] card_rank_q, card_rank_d;
  logic       underflow_q, underflow_d;
  logic [3:0] deck_q [52];
  logic [3:0] deck_d [52];

  logic [7:0] seed_nz;
  logic [5:0] j;
  logic [5:0] fill_mod;
  logic [3:0] fill_rank;
  logic [3:0] top_card;

  assign seed_nz   = (seed == '0) ? 8'h01 : seed;
  assign j         = lfsr_q[5:0];
  assign fill_mod  = i_q % 6'd13;
  assign fill_rank = fill_mod[3:0] + 4'd1;
  assign top_card  = deck_q[ptr_q];

  // Next-state, datapath and deck update for all phases.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    i_d          = i_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    card_valid_d = 1'b0;
    card_value_d = card_value_q;
    card_rank_d  = card_rank_q;
    underflow_d  = 1'b0;
    deck_d       = deck_q;

    case (state_q)
      S_IDLE: begin
        if (shuffle) begin
          state_d = S_FILL;
          i_d     = '0;
          lfsr_d  = seed_nz;
        end
      end

      S_FILL: begin
        deck_d[i_q] = fill_rank;
        if (i_q == 6'd51) begin
          state_d = S_SHUFFLE;
        end else begin
          i_d = i_q + 6'd1;
        end
      end

      S_SHUFFLE: begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // Rejection sampling: out-of-range candidates just burn a cycle.
        if (j <= i_q) begin
          deck_d[i_q] = deck_q[j];
          deck_d[j]   = deck_q[i_q];
          if (i_q == 6'd1) begin
            state_d     = S_READY;
            remaining_d = 6'd52;
            ptr_d       = '0;
          end else begin
            i_d = i_q - 6'd1;
          end
        end
      end

      S_READY: begin
        // A shuffle request takes precedence over a deal in the same cycle.
        if (shuffle) begin
          state_d     = S_FILL;
          i_d         = '0;
          lfsr_d      = seed_nz;
          ptr_d       = '0;
          remaining_d = '0;
        end else if (req) begin
          if (remaining_q != '0) begin
            card_rank_d  = top_card;
            card_value_d = (top_card > 4'd10) ? 5'd10 : {1'b0, top_card};
            card_valid_d = 1'b1;
            ptr_d        = ptr_q + 6'd1;
            remaining_d  = remaining_q - 6'd1;
          end else begin
            underflow_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= '0;
      i_q          <= '0;
      ptr_q        <= '0;
      remaining_q  <= '0;
      card_valid_q <= 1'b0;
      card_value_q <= '0;
      card_rank_q  <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      i_q          <= i_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      card_valid_q <= card_valid_d;
      card_value_q <= card_value_d;
      card_rank_q  <= card_rank_d;
      underflow_q  <= underflow_d;
    end
  end

  // Deck storage; contents are rebuilt by every fill so no reset is needed.
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign card_valid = card_valid_q;
  assign card_value = card_value_q;
  assign card_rank  = card_rank_q;
  assign remaining  = remaining_q;
  assign underflow  = underflow_q;
  assign ready      = (state_q == S_READY);
  assign busy       = (state_q == S_FILL) || (state_q == S_SHUFFLE);
  assign low_water  = ready && ({1'b0, remaining_q} < PEN_T);

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: scoreboard bench for card_shoe against a deck-level model.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seed;
  logic       shuffle;
  logic       req;
  logic       card_valid;
  logic [4:0] card_value;
  logic [3:0] card_rank;
  logic [5:0] remaining;
  logic       ready;
  logic       busy;
  logic       low_water;
  logic       underflow;

  card_shoe #(.PEN_THRESHOLD(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .shuffle    (shuffle),
    .req        (req),
    .card_valid (card_valid),
    .card_value (card_value),
    .card_rank  (card_rank),
    .remaining  (remaining),
    .ready      (ready),
    .busy       (busy),
    .low_water  (low_water),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] rank;
    logic [4:0] value;
    logic [5:0] rem;
  } exp_t;

  exp_t       card_q[$];
  int         uf_q[$];
  logic [3:0] dut_seq[$];
  logic [3:0] seq_a[$];
  int         rank_cnt[14];

  logic [3:0] mdeck[52];
  int         mptr;
  int         mrem;
  bit         mready;
  int         mshuf_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference: ordered deck, then Fisher-Yates from the top index down,
  // drawing candidates from the LFSR and discarding those above i.
  task automatic model_shuffle(input logic [7:0] s);
    logic [7:0] l;
    logic [3:0] t;
    int i, jj, cycles;
    l = (s == 8'h00) ? 8'h01 : s;
    for (int k = 0; k < 52; k++) mdeck[k] = 4'((k % 13) + 1);
    i = 51;
    cycles = 0;
    while (i >= 1) begin
      jj = int'(l[5:0]);
      cycles++;
      if (jj <= i) begin
        t = mdeck[i];
        mdeck[i] = mdeck[jj];
        mdeck[jj] = t;
        i--;
      end
      l = lfsr_next(l);
    end
    mshuf_cycles = cycles;
  endtask

  // Monitor: every strobe from the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (card_valid) begin
        if (card_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got card_valid=1 rank=%0d, expected no card", card_rank);
        end else begin
          exp_t e;
          e = card_q.pop_front();
          check("card_rank", card_rank, e.rank);
          check("card_value", card_value, e.value);
          check("remaining_after_deal", remaining, e.rem);
        end
        if (card_rank >= 4'd11) check("face_value_10", card_value, 10);
        dut_seq.push_back(card_rank);
        if (card_rank >= 4'd1 && card_rank <= 4'd13) rank_cnt[card_rank]++;
      end
      if (underflow) begin
        if (uf_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_underflow: got underflow=1, expected 0");
        end else begin
          void'(uf_q.pop_front());
          check("underflow_no_valid", card_valid, 0);
          check("underflow_remaining", remaining, 0);
        end
      end
    end
  end

  // One cycle of stimulus; the model predicts the DUT's reaction to req.
  task automatic step(input bit r);
    exp_t e;
    req = r;
    if (r && mready) begin
      if (mrem > 0) begin
        e.rank  = mdeck[mptr];
        e.value = (mdeck[mptr] > 4'd10) ? 5'd10 : {1'b0, mdeck[mptr]};
        e.rem   = 6'(mrem - 1);
        card_q.push_back(e);
        mptr++;
        mrem--;
      end else begin
        uf_q.push_back(1);
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic pulse_shuffle(input logic [7:0] s, input bit with_req);
    model_shuffle(s);
    dut_seq.delete();
    for (int k = 0; k < 14; k++) rank_cnt[k] = 0;
    mready  = 1'b0;
    mrem    = 0;
    mptr    = 0;
    seed    = s;
    shuffle = 1'b1;
    req     = with_req;
    @(posedge clk);
    #1;
    shuffle = 1'b0;
    req     = 1'b0;
    @(negedge clk);
    check("busy_after_shuffle", busy, 1);
    check("no_ready_after_shuffle", ready, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 1;
    while (!ready && n < 5000) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("shuffle_completes", ready, 1);
    check("shuffle_latency", n, 52 + mshuf_cycles);
    check("full_remaining", remaining, 52);
    check("busy_clear_ready", busy, 0);
    mready = 1'b1;
    mrem   = 52;
    mptr   = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit same;
    reset   = 1'b1;
    seed    = 8'h00;
    shuffle = 1'b0;
    req     = 1'b0;
    mready  = 1'b0;
    mrem    = 0;
    mptr    = 0;
    repeat (2) @(negedge clk);
    check("rst_card_valid", card_valid, 0);
    check("rst_card_value", card_value, 0);
    check("rst_card_rank", card_rank, 0);
    check("rst_remaining", remaining, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_low_water", low_water, 0);
    check("rst_underflow", underflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1);
    step(1'b0);

    // Zero seed is replaced by 8'h01; full deal, then underflow.
    pulse_shuffle(8'h00, 1'b0);
    wait_ready();
    repeat (52) step(1'b1);
    step(1'b0);
    for (int r = 1; r <= 13; r++) check("rank_count", rank_cnt[r], 4);
    check("empty_remaining", remaining, 0);
    step(1'b1);
    step(1'b0);
    check("remaining_stays_0", remaining, 0);

    // Seed reproducibility.
    pulse_shuffle(8'hA5, 1'b0);
    wait_ready();
    repeat (52) step(1'b1);
    step(1'b0);
    seq_a = dut_seq;
    pulse_shuffle(8'hA5, 1'b0);
    wait_ready();
    repeat (52) step(1'b1);
    step(1'b0);
    same = (dut_seq.size() == 52) && (seq_a.size() == 52);
    if (same) for (int k = 0; k < 52; k++) if (dut_seq[k] != seq_a[k]) same = 1'b0;
    check("a5_repeatable", same, 1);
    pulse_shuffle(8'h5A, 1'b0);
    wait_ready();
    repeat (52) step(1'b1);
    step(1'b0);
    same = (dut_seq.size() == 52);
    if (same) for (int k = 0; k < 52; k++) if (dut_seq[k] != seq_a[k]) same = 1'b0;
    check("5a_differs", same, 0);

    // Low-water boundary, then shuffle beating a same-cycle req.
    pulse_shuffle(8'h3C, 1'b0);
    wait_ready();
    repeat (37) step(1'b1);
    check("rem_15", remaining, 15);
    check("low_water_at_15", low_water, 0);
    step(1'b1);
    check("rem_14", remaining, 14);
    check("low_water_at_14", low_water, 1);
    step(1'b0);
    pulse_shuffle(8'h77, 1'b1);
    wait_ready();
    check("low_water_full", low_water, 0);

    // Randomized seeds and request patterns.
    for (int r = 0; r < 3; r++) begin
      pulse_shuffle(8'($urandom), 1'b0);
      wait_ready();
      repeat (60) step(1'($urandom_range(0, 1)));
      while (mrem > 0) step(1'b1);
      step(1'b1);
      step(1'b0);
    end

    // Reset in the middle of the shuffle phase.
    pulse_shuffle(8'hC3, 1'b0);
    repeat (70) @(posedge clk);
    #1;
    check("busy_mid_shuffle", busy, 1);
    reset  = 1'b1;
    mready = 1'b0;
    mrem   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 0);
    check("abort_remaining", remaining, 0);
    @(posedge clk);
    #1;
    repeat (3) begin
      step(1'b1);
      step(1'b0);
    end
    check("still_idle", ready, 0);

    step(1'b0);
    step(1'b0);
    check("cards_pending", card_q.size(), 0);
    check("underflows_pending", uf_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Card source for the blackjack datapath. Holds one 52-card deck in a register array, fills and Fisher-Yates shuffles it from an 8-bit LFSR seed, and deals one card per request through a one-cycle valid strobe. It sits directly upstream of the game controller: `card_value` drives the controller's 5-bit card input, and the controller's submit/hit pulses drive `req`. This replaces ad-hoc per-draw random values with dealing without replacement.

## Interface
- `PEN_THRESHOLD`, default 15: `low_water` asserts when `remaining < PEN_THRESHOLD`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `seed`  in  8  LFSR seed, sampled when a shuffle is accepted. A value of 0 is replaced by 8'h01.
- `shuffle`  in  1  pulse; starts fill+shuffle. Accepted in S_IDLE or S_READY only.
- `req`  in  1  deal request; sampled every cycle.
- `card_valid`  out  1  one-cycle strobe; a dealt card is present.
- `card_value`  out  5  blackjack value 1–10 (Ace=1, J/Q/K=10). Held until the next deal.
- `card_rank`  out  4  raw rank 1–13. Held until the next deal.
- `remaining`  out  6  undealt cards, 0–52.
- `ready`  out  1  high in S_READY.
- `busy`  out  1  high in S_FILL or S_SHUFFLE.
- `low_water`  out  1  `ready && remaining < PEN_THRESHOLD`.
- `underflow`  out  1  one-cycle pulse; `req` arrived in S_READY with `remaining==0`.

## Operation
- Storage is `deck[0:51]`, 4 bits per entry. There is a 6-bit index `i` and a 6-bit deal pointer `ptr`.
- LFSR: 8 bits, Fibonacci, shifts left.
  - New bit = `l[7]^l[5]^l[4]^l[3]`.
  - Advances every cycle in S_SHUFFLE and only then.
- **S_IDLE** (after reset)
  - `shuffle` → S_FILL with `i=0`, and LFSR loaded with `seed` (or 8'h01 if `seed` is 0).
- **S_FILL**
  - Each cycle writes `deck[i] = (i mod 13)+1` and increments `i`.
  - After `i=51` is written: `i=51`, go to S_SHUFFLE. Takes exactly 52 cycles.
- **S_SHUFFLE** (rejection sampling)
  - Candidate `j = lfsr[5:0]`.
  - If `j <= i`: swap `deck[i]` and `deck[j]` in the same cycle (`j==i` is a legal no-op swap), then decrement `i`.
  - Otherwise no swap and `i` is unchanged.
  - When a swap executes with `i==1`: go to S_READY, with `remaining=52` and `ptr=0`.
- **S_READY**
  - `req && remaining>0`: `card_rank<=deck[ptr]` and `card_value<=min(deck[ptr],10)`. `card_valid` pulses, `ptr` increments, `remaining` decrements.
  - `req && remaining==0`: `underflow` pulses; no valid strobe, no other change.
  - `shuffle` → S_FILL (reseed, as in S_IDLE); the remaining cards are discarded.
- Priority: if `shuffle` and `req` arrive in the same S_READY cycle, `shuffle` wins and no card is dealt.
- `shuffle` in S_FILL/S_SHUFFLE is ignored. `req` outside S_READY is ignored silently: no valid, no underflow.
- `remaining` is 6-bit unsigned, never wraps, and saturates at 0 by the rule above. `ptr` never exceeds 52.
- Output is deterministic: identical `seed` gives an identical deal order.

## Timing
- Reset value of every output is 0, including `card_value`, `card_rank` and `remaining`.
- On reset:
  - State goes to S_IDLE, and LFSR, `i` and `ptr` go to 0.
  - Deck contents are don't-care.
  - `reset` mid-fill or mid-shuffle aborts immediately; a new `shuffle` is required.
- Shuffle latency:
  - `busy` rises the cycle after `shuffle` is sampled.
  - 52 fill cycles, plus 51 accepted swaps, plus any rejected cycles.
  - `ready` rises the cycle after the final swap.
- Deal latency:
  - `req` sampled at edge N gives `card_valid`, `card_value`, `card_rank` and the updated `remaining` after edge N.
  - Back-to-back `req` every cycle gives one card per cycle.
  - `card_valid` is never high for 2 cycles from a single-cycle `req`.
- `low_water` and `ready` are combinational from state and the `remaining` register, with no extra latency.

## Test plan
- Reset with `seed=8'h00` → all outputs 0 and `busy=0`.
  - Pulse `shuffle` → `busy=1` next cycle.
  - `ready` eventually =1 with `remaining=52`; fill phase is exactly 52 cycles.
- After shuffle, hold `req` high 52 cycles → 52 `card_valid` strobes.
  - Each rank 1–13 appears exactly 4 times.
  - `card_value` is 10 whenever `card_rank` is 11–13.
  - `remaining` counts 51…0.
- With `remaining=0`, pulse `req` → `underflow=1` for one cycle, `card_valid=0`, `remaining` stays 0.
- With `PEN_THRESHOLD=15`: `low_water=0` at `remaining=15` and `low_water=1` at `remaining=14`.
  - Then `shuffle`+`req` in the same cycle → no `card_valid`, `busy=1`, and `remaining` is 52 after completion.
- Two shuffles with `seed=8'hA5` give identical 52-card sequences. `seed=8'h5A` gives a different sequence.
- Assert `reset` mid-S_SHUFFLE → next cycle `busy=0`, `ready=0`, `remaining=0`.
  - `req` pulses produce no `card_valid` and no `underflow`.
